// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES phase accumulators between note-on/off events.
// Latency: an accepted event updates the voice outputs NUM_VOICES+1 edges after its handshake.
// Backpressure: ev_ready is low while an event is scanned and committed; one event per NUM_VOICES+2 cycles.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   ev_valid/ev_ready   - event handshake; ev_on/ev_note/ev_step sampled only at the handshake edge
//   voice_step          - packed per-voice phase increment, voice v at [v*STEP_WIDTH +: STEP_WIDTH]
//   voice_note          - packed per-voice note number, voice v at [v*7 +: 7]
//   voice_gate          - per-voice held flag
//   voice_reset         - per-voice one-cycle pulse that restarts the accumulator on (re)trigger
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int STEP_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ev_valid,
    output logic                             ev_ready,
    input  logic                             ev_on,
    input  logic [6:0]                       ev_note,
    input  logic [STEP_WIDTH-1:0]            ev_step,
    output logic [NUM_VOICES*STEP_WIDTH-1:0] voice_step,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES-1:0]            voice_reset,
    output logic [NUM_VOICES*7-1:0]          voice_note
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]            state;
    logic                  ready_q;

    // Event latched at the handshake edge.
    logic                  lat_on;
    logic [6:0]            lat_note;
    logic [STEP_WIDTH-1:0] lat_step;

    // Scan results.
    logic [IW-1:0]         scan_idx;
    logic                  match_found;
    logic [IW-1:0]         match_idx;
    logic                  free_found;
    logic [IW-1:0]         free_idx;
    logic [NUM_VOICES-1:0] match_mask;

    logic [IW-1:0]         steal_ptr;

    // Per-voice state.
    logic [STEP_WIDTH-1:0] step_q [NUM_VOICES];
    logic [6:0]            note_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] rst_q;

    // Voice under examination this SCAN cycle.
    logic                  cur_gate;
    logic                  cur_match;

    // Note-on target: retrigger beats free beats steal.
    logic [IW-1:0]         tgt;
    logic                  is_steal;

    always_comb begin
        cur_gate  = gate_q[scan_idx];
        cur_match = cur_gate && (note_q[scan_idx] == lat_note);
    end

    always_comb begin
        is_steal = 1'b0;
        if (match_found) begin
            tgt = match_idx;
        end else if (free_found) begin
            tgt = free_idx;
        end else begin
            tgt      = steal_ptr;
            is_steal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_step    <= '0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            match_mask  <= '0;
            steal_ptr   <= '0;
            gate_q      <= '0;
            rst_q       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                step_q[v] <= '0;
                note_q[v] <= '0;
            end
        end else begin
            // voice_reset is a pulse: only the COMMIT cycle raises a bit.
            rst_q <= '0;
            case (state)
                IDLE: begin
                    if (ev_valid && ready_q) begin
                        lat_on      <= ev_on;
                        lat_note    <= ev_note;
                        lat_step    <= ev_step;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        match_mask  <= '0;
                        ready_q     <= 1'b0;
                        state       <= SCAN;
                    end else begin
                        // Also how ready first rises one edge after reset release.
                        ready_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cur_match) begin
                        match_mask[scan_idx] <= 1'b1;
                        if (!match_found) begin
                            match_found <= 1'b1;
                            match_idx   <= scan_idx;
                        end
                    end
                    if (!cur_gate && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + IW'(1);
                    end
                end
                COMMIT: begin
                    if (lat_on) begin
                        step_q[tgt] <= lat_step;
                        note_q[tgt] <= lat_note;
                        gate_q[tgt] <= 1'b1;
                        rst_q[tgt]  <= 1'b1;
                        // Pointer moves only when a held voice is taken over.
                        if (is_steal) begin
                            steal_ptr <= (steal_ptr == LAST_IDX) ? '0 : steal_ptr + IW'(1);
                        end
                    end else begin
                        // Empty mask leaves gates untouched; step/note are kept for release tails.
                        gate_q <= gate_q & ~match_mask;
                    end
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ev_ready    = ready_q;
    assign voice_gate  = gate_q;
    assign voice_reset = rst_q;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign voice_step[v*STEP_WIDTH +: STEP_WIDTH] = step_q[v];
        assign voice_note[v*7 +: 7]                   = note_q[v];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4, STEP_WIDTH=32): vector table
// for allocation/retrigger/note-off/steal, plus reset-mid-scan and back-pressure sequences.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int SW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ev_valid = 1'b0;
    logic            ev_ready;
    logic            ev_on = 1'b0;
    logic [6:0]      ev_note = '0;
    logic [SW-1:0]   ev_step = '0;
    logic [NV*SW-1:0] voice_step;
    logic [NV-1:0]   voice_gate;
    logic [NV-1:0]   voice_reset;
    logic [NV*7-1:0] voice_note;

    int n_chk = 0;
    int n_fail = 0;

    voice_allocator #(.NUM_VOICES(NV), .STEP_WIDTH(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .ev_step    (ev_step),
        .voice_step (voice_step),
        .voice_gate (voice_gate),
        .voice_reset(voice_reset),
        .voice_note (voice_note)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        on;
        logic [6:0]  note;
        logic [31:0] step;
        logic [3:0]  gate;
        logic [3:0]  rst;
        int          v;
        logic [6:0]  vnote;
        logic [31:0] vstep;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] vnote_of(input int v);
        return voice_note[v*7 +: 7];
    endfunction

    function automatic logic [31:0] vstep_of(input int v);
        return voice_step[v*SW +: SW];
    endfunction

    // Assert reset, check cleared outputs, release and check ready timing.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_gate", 128'(voice_gate), 128'd0);
        check("rst_pulse", 128'(voice_reset), 128'd0);
        check("rst_step", 128'(voice_step), 128'd0);
        check("rst_note", 128'(voice_note), 128'd0);
        check("rst_ready", 128'(ev_ready), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_ready_low", 128'(ev_ready), 128'd0);
        @(posedge clk);
        #1;
        check("rel_ready_high", 128'(ev_ready), 128'd1);
        check("rel_gate", 128'(voice_gate), 128'd0);
    endtask

    // Offer one event; returns with time just after the commit edge.
    task automatic send(input logic on, input logic [6:0] n, input logic [31:0] s,
                        output logic [3:0] pulse, output int low_cnt);
        int t;
        t = 0;
        @(negedge clk);
        while (!ev_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ev_ready) check("ready_timeout", 128'd0, 128'd1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = n;
        ev_step  = s;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        ev_on    = ~on;
        ev_note  = ~n;
        ev_step  = ~s;
        low_cnt  = 0;
        while (!ev_ready && low_cnt < 12) begin
            low_cnt++;
            @(posedge clk);
            #1;
        end
        pulse = voice_reset;
    endtask

    initial begin
        logic [3:0] pulse;
        int         low_cnt;
        int         last;
        int         hs;
        logic [6:0] acc [$];

        tbl[0]  = '{1'b1, 7'd60, 32'd100000, 4'b0001, 4'b0001, 0, 7'd60, 32'd100000};
        tbl[1]  = '{1'b1, 7'd64, 32'd126000, 4'b0011, 4'b0010, 1, 7'd64, 32'd126000};
        tbl[2]  = '{1'b1, 7'd60, 32'd200000, 4'b0011, 4'b0001, 0, 7'd60, 32'd200000};
        tbl[3]  = '{1'b0, 7'd64, 32'hDEAD,   4'b0001, 4'b0000, 1, 7'd64, 32'd126000};
        tbl[4]  = '{1'b1, 7'd62, 32'd5000,   4'b0011, 4'b0010, 1, 7'd62, 32'd5000};
        tbl[5]  = '{1'b1, 7'd64, 32'd7000,   4'b0111, 4'b0100, 2, 7'd64, 32'd7000};
        tbl[6]  = '{1'b0, 7'd62, 32'hDEAD,   4'b0101, 4'b0000, 1, 7'd62, 32'd5000};
        tbl[7]  = '{1'b0, 7'd99, 32'hDEAD,   4'b0101, 4'b0000, 1, 7'd62, 32'd5000};
        tbl[8]  = '{1'b1, 7'd61, 32'd0,      4'b0111, 4'b0010, 1, 7'd61, 32'd0};
        tbl[9]  = '{1'b1, 7'd63, 32'd9,      4'b1111, 4'b1000, 3, 7'd63, 32'd9};
        tbl[10] = '{1'b1, 7'd70, 32'd1,      4'b1111, 4'b0001, 0, 7'd70, 32'd1};
        tbl[11] = '{1'b1, 7'd71, 32'd2,      4'b1111, 4'b0010, 1, 7'd71, 32'd2};
        tbl[12] = '{1'b1, 7'd72, 32'd3,      4'b1111, 4'b0100, 2, 7'd72, 32'd3};
        tbl[13] = '{1'b1, 7'd73, 32'd4,      4'b1111, 4'b1000, 3, 7'd73, 32'd4};
        tbl[14] = '{1'b1, 7'd74, 32'd5,      4'b1111, 4'b0001, 0, 7'd74, 32'd5};
        tbl[15] = '{1'b1, 7'd71, 32'd22,     4'b1111, 4'b0010, 1, 7'd71, 32'd22};
        tbl[16] = '{1'b0, 7'd74, 32'hDEAD,   4'b1110, 4'b0000, 0, 7'd74, 32'd5};
        tbl[17] = '{1'b1, 7'd80, 32'd8,      4'b1111, 4'b0001, 0, 7'd80, 32'd8};
        tbl[18] = '{1'b1, 7'd81, 32'd9,      4'b1111, 4'b0010, 1, 7'd81, 32'd9};

        #12;
        do_reset();

        for (int i = 0; i < 19; i++) begin
            send(tbl[i].on, tbl[i].note, tbl[i].step, pulse, low_cnt);
            check($sformatf("v%0d_ready_low", i), 128'(low_cnt), 128'd5);
            check($sformatf("v%0d_pulse", i), 128'(pulse), 128'(tbl[i].rst));
            check($sformatf("v%0d_gate", i), 128'(voice_gate), 128'(tbl[i].gate));
            check($sformatf("v%0d_note", i), 128'(vnote_of(tbl[i].v)), 128'(tbl[i].vnote));
            check($sformatf("v%0d_step", i), 128'(vstep_of(tbl[i].v)), 128'(tbl[i].vstep));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse_end", i), 128'(voice_reset), 128'd0);
        end

        // Reset in the middle of a note-on scan discards it.
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd90;
        ev_step  = 32'd1234;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        send(1'b1, 7'd90, 32'd100000, pulse, low_cnt);
        check("post_rst_pulse", 128'(pulse), 128'b0001);
        check("post_rst_gate", 128'(voice_gate), 128'b0001);
        send(1'b1, 7'd90, 32'd200000, pulse, low_cnt);
        check("retrig_pulse", 128'(pulse), 128'b0001);
        check("retrig_gate", 128'(voice_gate), 128'b0001);
        check("retrig_step", 128'(vstep_of(0)), 128'd200000);

        // Back-pressure: valid held high, note changes every cycle.
        @(negedge clk);
        do_reset();
        last = -1;
        hs = 0;
        ev_on    = 1'b1;
        ev_step  = 32'd77;
        ev_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            ev_note = 7'(20 + c);
            #1;
            if (ev_ready) begin
                if (last >= 0) check("bp_interval", 128'(c - last), 128'd6);
                last = c;
                hs++;
                acc.push_back(ev_note);
            end
        end
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_count", 128'(hs), 128'd7);
        if (acc.size() == 7) begin
            check("bp_v0", 128'(vnote_of(0)), 128'(acc[4]));
            check("bp_v1", 128'(vnote_of(1)), 128'(acc[5]));
            check("bp_v2", 128'(vnote_of(2)), 128'(acc[6]));
            check("bp_v3", 128'(vnote_of(3)), 128'(acc[3]));
        end
        check("bp_gate", 128'(voice_gate), 128'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
